// File: rtl/tri_pkg.sv
// Shared types and constants for the trilateration range generator and its
// sequential square-root engine.
package tri_pkg;

  localparam int N_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    SQR,
    ROOT,
    RND,
    DONE
  } state_t;

  localparam logic [1:0] ANC_A = 2'd0;
  localparam logic [1:0] ANC_B = 2'd1;
  localparam logic [1:0] ANC_C = 2'd2;

  // One root bit per cycle, so an N-bit coordinate space needs N+1 cycles.
  function automatic int root_iters(input int n);
    return n + 1;
  endfunction

  localparam int ROOT_ITERS = root_iters(N_DEF);

endpackage

// File: rtl/tri_isqrt_seq.sv
// Restoring bit-serial integer square root: RW result bits, MSB first,
// one bit per clock after start; yields floor(sqrt(d2)) and d2 - root^2.
module tri_isqrt_seq #(
  parameter int RW = 9
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2*RW-1:0] d2,
  output logic            busy,
  output logic            done,
  output logic [RW-1:0]   root,
  output logic [RW:0]     rem
);

  localparam int CW = $clog2(RW + 1);

  logic [2*RW-1:0] rad;
  logic [CW-1:0]   cnt;
  logic [RW+2:0]   acc;
  logic [RW+2:0]   trial;
  logic [RW+2:0]   diff;
  logic [RW-1:0]   next_root;
  logic [RW:0]     next_rem;

  // The remainder never exceeds 2*root, so RW+1 bits hold it between steps.
  always_comb begin
    acc       = {rem, rad[2*RW-1 -: 2]};
    trial     = {1'b0, root, 2'b01};
    diff      = acc - trial;
    next_root = {root[RW-2:0], 1'b0};
    next_rem  = acc[RW:0];
    if (acc >= trial) begin
      next_root = {root[RW-2:0], 1'b1};
      next_rem  = diff[RW:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rad  <= '0;
      cnt  <= '0;
      root <= '0;
      rem  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else if (start) begin
      rad  <= d2;
      cnt  <= CW'(RW);
      root <= '0;
      rem  <= '0;
      busy <= 1'b1;
      done <= 1'b0;
    end else if (busy) begin
      rad  <= {rad[2*RW-3:0], 2'b00};
      root <= next_root;
      rem  <= next_rem;
      cnt  <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/tri_range_gen.sv
// Forward model for the trilateration solver: rounded Euclidean distance from
// target M to anchors A, B, C, computed in turn through one shared root engine.
module tri_range_gen
  import tri_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [N-1:0] xA,
  input  logic signed [N-1:0] yA,
  input  logic signed [N-1:0] xB,
  input  logic signed [N-1:0] yB,
  input  logic signed [N-1:0] xC,
  input  logic signed [N-1:0] yC,
  input  logic signed [N-1:0] xM,
  input  logic signed [N-1:0] yM,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N:0]          rA,
  output logic [N:0]          rB,
  output logic [N:0]          rC
);

  localparam int RW = root_iters(N);
  localparam int DW = 2 * N + 2;
  localparam int CW = $clog2(RW);

  state_t state, next_state;

  logic signed [N-1:0] cap_xa, cap_ya, cap_xb, cap_yb, cap_xc, cap_yc, cap_xm, cap_ym;
  logic [1:0]          anchor;
  logic [CW-1:0]       cnt;

  logic signed [N-1:0] xk, yk;
  logic signed [N:0]   dx, dy;
  logic signed [DW-1:0] dxe, dye;
  logic [DW-1:0]       d2;
  logic                start;
  logic                sqrt_busy, sqrt_done;
  logic [RW-1:0]       root;
  logic [RW:0]         rem;
  logic [RW:0]         rnd_sum;
  logic [N:0]          rounded;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Differences are taken one bit wider than the coordinates so they cannot wrap.
  always_comb begin
    xk = cap_xa;
    yk = cap_ya;
    case (anchor)
      ANC_B:   begin xk = cap_xb; yk = cap_yb; end
      ANC_C:   begin xk = cap_xc; yk = cap_yc; end
      default: begin xk = cap_xa; yk = cap_ya; end
    endcase
    dx  = {cap_xm[N-1], cap_xm} - {xk[N-1], xk};
    dy  = {cap_ym[N-1], cap_ym} - {yk[N-1], yk};
    dxe = DW'(dx);
    dye = DW'(dy);
    d2  = DW'(dxe * dxe) + DW'(dye * dye);
  end

  // Round to nearest: rem > r means d2 lies past (r + 0.5)^2.
  always_comb begin
    rnd_sum = {1'b0, root} + (RW + 1)'(rem > (RW + 1)'(root));
    rounded = rnd_sum[RW] ? {(N + 1){1'b1}} : rnd_sum[N:0];
  end

  tri_isqrt_seq #(
    .RW(RW)
  ) u_isqrt (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .d2   (d2),
    .busy (sqrt_busy),
    .done (sqrt_done),
    .root (root),
    .rem  (rem)
  );

  always_comb begin
    next_state = state;
    start      = 1'b0;
    case (state)
      IDLE: if (in_valid) next_state = SQR;
      SQR: begin
        start      = 1'b1;
        next_state = ROOT;
      end
      ROOT: if (cnt == '0) next_state = RND;
      RND:  next_state = (anchor == ANC_C) ? DONE : SQR;
      DONE: if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cap_xa <= '0;
      cap_ya <= '0;
      cap_xb <= '0;
      cap_yb <= '0;
      cap_xc <= '0;
      cap_yc <= '0;
      cap_xm <= '0;
      cap_ym <= '0;
      anchor <= ANC_A;
      cnt    <= '0;
      rA     <= '0;
      rB     <= '0;
      rC     <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: if (in_valid) begin
          cap_xa <= xA;
          cap_ya <= yA;
          cap_xb <= xB;
          cap_yb <= yB;
          cap_xc <= xC;
          cap_yc <= yC;
          cap_xm <= xM;
          cap_ym <= yM;
          anchor <= ANC_A;
        end
        SQR:  cnt <= CW'(RW - 1);
        ROOT: cnt <= cnt - CW'(1);
        RND: begin
          if (sqrt_done && !sqrt_busy) begin
            case (anchor)
              ANC_A:   rA <= rounded;
              ANC_B:   rB <= rounded;
              default: rC <= rounded;
            endcase
          end
          anchor <= anchor + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tri_range_gen.sv
// Scoreboard bench for tri_range_gen: requests push hand-computed ranges,
// a negedge monitor pops and compares whenever a result is handed over.
module tb_tri_range_gen;

  localparam int N = 8;
  localparam int LAT = 3 * (N + 3);

  logic                clk = 1'b0;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic signed [N-1:0] xA, yA, xB, yB, xC, yC, xM, yM;
  logic                out_valid;
  logic                out_ready;
  logic [N:0]          rA, rB, rC;

  typedef struct {
    int ra;
    int rb;
    int rc;
    int acc_cycle;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cycle = 0;
  int   last_take = -1;
  int   accept_cycle = 0;
  bit   prev_valid = 1'b0;

  tri_range_gen #(.N(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .xA       (xA),
    .yA       (yA),
    .xB       (xB),
    .yB       (yB),
    .xC       (xC),
    .yC       (yC),
    .xM       (xM),
    .yM       (yM),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .rA       (rA),
    .rB       (rB),
    .rC       (rC)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check_output(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic set_coords(input int xa, input int ya, input int xb, input int yb,
                            input int xc, input int yc, input int xm, input int ym);
    xA = N'(xa); yA = N'(ya);
    xB = N'(xb); yB = N'(yb);
    xC = N'(xc); yC = N'(yc);
    xM = N'(xm); yM = N'(ym);
  endtask

  // Presents one request, waits for the accepting edge and queues its expectation.
  task automatic apply_stimulus(input int xa, input int ya, input int xb, input int yb,
                                input int xc, input int yc, input int xm, input int ym,
                                input int era, input int erb, input int erc);
    exp_t e;
    int   waited;
    @(posedge clk);
    #1;
    set_coords(xa, ya, xb, yb, xc, yc, xm, ym);
    in_valid = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check_output("accept_timeout", 0, 1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      accept_cycle = cycle;
      e.ra = era;
      e.rb = erb;
      e.rc = erc;
      e.acc_cycle = accept_cycle;
      sb.push_back(e);
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int waited;
    waited = 0;
    while ((sb.size() != 0 || out_valid) && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (sb.size() != 0) check_output("drain_timeout", sb.size(), 0);
  endtask

  // Monitor: latency on the rising edge of out_valid, values on each handover.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid && !prev_valid) begin
        if (sb.size() == 0) check_output("spurious_out_valid", 1, 0);
        else check_output("latency", cycle - sb[0].acc_cycle, LAT);
      end
      if (out_valid && out_ready && sb.size() != 0) begin
        e = sb.pop_front();
        check_output("rA", int'(rA), e.ra);
        check_output("rB", int'(rB), e.rb);
        check_output("rC", int'(rC), e.rc);
        last_take = cycle;
      end
      prev_valid = out_valid;
    end
  end

  initial begin
    int waited;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    set_coords(0, 0, 0, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_in_ready", int'(in_ready), 1);
    check_output("reset_out_valid", int'(out_valid), 0);
    check_output("reset_rA", int'(rA), 0);
    check_output("reset_rB", int'(rB), 0);
    check_output("reset_rC", int'(rC), 0);
    rst_n = 1'b1;

    $display("[TB] nominal");
    apply_stimulus(-16, -111, 109, -99, -32, 108, 0, 0, 112, 147, 113);
    wait_drain();

    $display("[TB] coincident");
    apply_stimulus(5, -7, 5, -7, 5, -7, 5, -7, 0, 0, 0);
    wait_drain();

    $display("[TB] extreme");
    apply_stimulus(-128, -128, 127, 127, 127, 127, 127, 127, 361, 0, 0);
    wait_drain();

    $display("[TB] backpressure");
    @(posedge clk);
    #1 out_ready = 1'b0;
    apply_stimulus(13, 24, 0, 0, -20, -20, 10, 20, 5, 22, 50);
    waited = 0;
    while (!out_valid && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!out_valid) check_output("bp_valid_timeout", 0, 1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (i == 3) begin
        set_coords(-128, -128, -128, -128, -128, -128, 127, 127);
        in_valid = 1'b1;
      end
      if (i == 4) in_valid = 1'b0;
      @(negedge clk);
      check_output("bp_hold_rA", int'(rA), 5);
      check_output("bp_hold_rB", int'(rB), 22);
      check_output("bp_hold_rC", int'(rC), 50);
      check_output("bp_in_ready", int'(in_ready), 0);
      check_output("bp_out_valid", int'(out_valid), 1);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_output("bp_release_in_ready", int'(in_ready), 1);
    check_output("bp_release_out_valid", int'(out_valid), 0);
    repeat (3) @(negedge clk);
    check_output("bp_ignored_request", int'(in_ready), 1);
    wait_drain();

    $display("[TB] reset mid-operation");
    apply_stimulus(-16, -111, 109, -99, -32, 108, 0, 0, 112, 147, 113);
    repeat (15) @(posedge clk);
    #1;
    check_output("midop_rA_before_reset", int'(rA), 112);
    rst_n = 1'b0;
    #1;
    check_output("midop_out_valid", int'(out_valid), 0);
    check_output("midop_in_ready", int'(in_ready), 1);
    check_output("midop_rA", int'(rA), 0);
    check_output("midop_rB", int'(rB), 0);
    check_output("midop_rC", int'(rC), 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    apply_stimulus(-16, -111, 109, -99, -32, 108, 0, 0, 112, 147, 113);
    wait_drain();

    $display("[TB] back-to-back");
    apply_stimulus(27, -77, -100, 50, -99, 51, -100, 50, 180, 0, 1);
    apply_stimulus(13, 24, 0, 0, -20, -20, 10, 20, 5, 22, 50);
    check_output("b2b_accept_gap", accept_cycle - last_take, 2);
    wait_drain();

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
